// File: rtl/axi_burst_splitter_pkg.sv
// Shared definitions for the AXI burst splitter: burst type codes, the
// address-channel FSM state type and a helper that recognises legal WRAP lengths.
package axi_burst_splitter_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats; anything else falls back to INCR.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator, shared by the address-channel
// splitter and the data-side address tracker.
module axi_burst_addr_gen
    import axi_burst_splitter_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [2:0]           size_i,
    input  logic [1:0]           burst_i,
    input  logic [7:0]           len_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    localparam logic [AddrWidth-1:0] ONE = AddrWidth'(1);

    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] aligned;
    logic [AddrWidth-1:0] incr_addr;
    logic [AddrWidth-1:0] wrap_mask;

    // Arithmetic stays at AddrWidth so an INCR past the top of memory truncates to zero.
    always_comb begin
        step      = ONE << size_i;
        aligned   = addr_i & ~(step - ONE);
        incr_addr = aligned + step;
        wrap_mask = ((AddrWidth'(len_i) + ONE) << size_i) - ONE;

        next_addr_o = incr_addr;
        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP: begin
                if (is_wrap_len(len_i)) begin
                    next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_splitter_ax_split.sv
// Address-channel front end of the AXI burst splitter: accepts one burst,
// allocates a beat-counter slot for it, then emits len+1 single-beat requests.
module axi_burst_splitter_ax_split
    import axi_burst_splitter_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned MiscWidth = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    input  logic [UserWidth-1:0] ax_user_i,
    input  logic [MiscWidth-1:0] ax_misc_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,

    output logic [IdWidth-1:0]   alloc_id_o,
    output logic [7:0]           alloc_len_o,
    output logic                 alloc_req_o,
    input  logic                 alloc_gnt_i,

    output logic [IdWidth-1:0]   ax_id_o,
    output logic [AddrWidth-1:0] ax_addr_o,
    output logic [7:0]           ax_len_o,
    output logic [2:0]           ax_size_o,
    output logic [1:0]           ax_burst_o,
    output logic [UserWidth-1:0] ax_user_o,
    output logic [MiscWidth-1:0] ax_misc_o,
    output logic                 ax_last_o,
    output logic                 ax_valid_o,
    input  logic                 ax_ready_i
);

    state_e               state_q, state_d;
    logic [7:0]           rem_q, rem_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [7:0]           len_q, len_d;
    logic [UserWidth-1:0] user_q, user_d;
    logic [MiscWidth-1:0] misc_q, misc_d;

    logic [AddrWidth-1:0] next_addr;
    logic                 accept;
    logic                 beat_done;

    axi_burst_addr_gen #(
        .AddrWidth (AddrWidth)
    ) i_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .len_i       (len_q),
        .next_addr_o (next_addr)
    );

    // Upstream accept and counter allocation are the same event, so ready needs the grant.
    assign accept    = (state_q == IDLE) & ax_valid_i & alloc_gnt_i & ~rst_i;
    assign beat_done = (state_q == BUSY) & ax_ready_i & ~rst_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        id_d    = id_q;
        size_d  = size_q;
        burst_d = burst_q;
        len_d   = len_q;
        user_d  = user_q;
        misc_d  = misc_q;

        ax_ready_o  = 1'b0;
        ax_valid_o  = 1'b0;
        ax_last_o   = 1'b0;
        alloc_req_o = 1'b0;
        alloc_id_o  = ax_id_i;
        alloc_len_o = ax_len_i;

        unique case (state_q)
            IDLE: begin
                alloc_req_o = ax_valid_i & ~rst_i;
                ax_ready_o  = accept;
                if (accept) begin
                    id_d    = ax_id_i;
                    addr_d  = ax_addr_i;
                    size_d  = ax_size_i;
                    burst_d = ax_burst_i;
                    len_d   = ax_len_i;
                    user_d  = ax_user_i;
                    misc_d  = ax_misc_i;
                    rem_d   = ax_len_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                ax_valid_o = ~rst_i;
                ax_last_o  = (rem_q == 8'd0);
                if (beat_done) begin
                    if (rem_q != 8'd0) begin
                        rem_d  = rem_q - 8'd1;
                        addr_d = next_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            size_q  <= '0;
            burst_q <= '0;
            len_q   <= '0;
            user_q  <= '0;
            misc_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            len_q   <= len_d;
            user_q  <= user_d;
            misc_q  <= misc_d;
        end
    end

    // Every emitted request is a single INCR beat.
    assign ax_id_o    = id_q;
    assign ax_addr_o  = addr_q;
    assign ax_len_o   = 8'd0;
    assign ax_size_o  = size_q;
    assign ax_burst_o = BURST_INCR;
    assign ax_user_o  = user_q;
    assign ax_misc_o  = misc_q;

endmodule

// File: tb/tb_axi_burst_splitter_ax_split.sv
// Self-checking bench for the AX splitter: a queue-based model of expected beats
// plus literal address sequences for the hand-worked bursts.
module tb_axi_burst_splitter_ax_split;
    import axi_burst_splitter_pkg::*;

    localparam int AW = 64;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int MW = 20;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [IW-1:0] ax_id_i;
    logic [AW-1:0] ax_addr_i;
    logic [7:0]    ax_len_i;
    logic [2:0]    ax_size_i;
    logic [1:0]    ax_burst_i;
    logic [UW-1:0] ax_user_i;
    logic [MW-1:0] ax_misc_i;
    logic          ax_valid_i;
    logic          ax_ready_o;
    logic [IW-1:0] alloc_id_o;
    logic [7:0]    alloc_len_o;
    logic          alloc_req_o;
    logic          alloc_gnt_i;
    logic [IW-1:0] ax_id_o;
    logic [AW-1:0] ax_addr_o;
    logic [7:0]    ax_len_o;
    logic [2:0]    ax_size_o;
    logic [1:0]    ax_burst_o;
    logic [UW-1:0] ax_user_o;
    logic [MW-1:0] ax_misc_o;
    logic          ax_last_o;
    logic          ax_valid_o;
    logic          ax_ready_i;

    axi_burst_splitter_ax_split #(
        .AddrWidth (AW), .IdWidth (IW), .UserWidth (UW), .MiscWidth (MW)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .ax_id_i (ax_id_i), .ax_addr_i (ax_addr_i), .ax_len_i (ax_len_i),
        .ax_size_i (ax_size_i), .ax_burst_i (ax_burst_i), .ax_user_i (ax_user_i),
        .ax_misc_i (ax_misc_i), .ax_valid_i (ax_valid_i), .ax_ready_o (ax_ready_o),
        .alloc_id_o (alloc_id_o), .alloc_len_o (alloc_len_o), .alloc_req_o (alloc_req_o),
        .alloc_gnt_i (alloc_gnt_i),
        .ax_id_o (ax_id_o), .ax_addr_o (ax_addr_o), .ax_len_o (ax_len_o),
        .ax_size_o (ax_size_o), .ax_burst_o (ax_burst_o), .ax_user_o (ax_user_o),
        .ax_misc_o (ax_misc_o), .ax_last_o (ax_last_o), .ax_valid_o (ax_valid_o),
        .ax_ready_i (ax_ready_i)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] addr;
        logic        last;
    } beat_t;

    beat_t         exp_q[$];
    logic [IW-1:0] cur_id;
    logic [2:0]    cur_size;
    logic [UW-1:0] cur_user;
    logic [MW-1:0] cur_misc;
    int            acc_cnt = 0;
    time           acc_time[$];
    logic [63:0]   log_addr[$];
    logic          log_last[$];
    logic [63:0]   want_addr[$];
    logic          want_last[$];
    int            errors = 0;
    int            checks = 0;
    bit            check_en = 1'b0;
    bit            rand_mode = 1'b0;

    // Address of beat i from the AXI burst rules, written as plain arithmetic.
    function automatic logic [63:0] beatAddr(input logic [63:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
        logic [63:0] step, astart, total, base;
        step   = 64'd1 << size;
        astart = addr - (addr % step);
        if (burst == BURST_FIXED || i == 0) return addr;
        if (burst == BURST_WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            total = (64'(len) + 64'd1) * step;
            base  = astart - (astart % total);
            return base + ((astart - base + 64'(i) * step) % total);
        end
        return astart + 64'(i) * step;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, " beat count"}, 64'(log_addr.size()), 64'(want_addr.size()));
        for (int i = 0; i < want_addr.size() && i < log_addr.size(); i++) begin
            checkOutput({name, " beat addr"}, log_addr[i], want_addr[i]);
            checkOutput({name, " beat last"}, 64'(log_last[i]), 64'(want_last[i]));
        end
    endtask

    // Model: an accepted burst becomes a queue of expected beats; each handshake pops one.
    always @(posedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (ax_valid_i && alloc_gnt_i) begin
                for (int i = 0; i <= int'(ax_len_i); i++)
                    exp_q.push_back('{addr: beatAddr(ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, i),
                                      last: (i == int'(ax_len_i))});
                cur_id   = ax_id_i;
                cur_size = ax_size_i;
                cur_user = ax_user_i;
                cur_misc = ax_misc_i;
                acc_cnt++;
                acc_time.push_back($time);
            end
        end else if (ax_ready_i) begin
            exp_q.delete(0);
        end
    end

    // Compare process: every output against the model, sampled mid-cycle.
    always @(negedge clk_i) begin
        bit ev, er, eq;
        if (check_en) begin
            ev = !rst_i && exp_q.size() != 0;
            eq = !rst_i && exp_q.size() == 0 && ax_valid_i;
            er = eq && alloc_gnt_i;
            checkOutput("ax_valid_o", 64'(ax_valid_o), 64'(ev));
            checkOutput("ax_ready_o", 64'(ax_ready_o), 64'(er));
            checkOutput("alloc_req_o", 64'(alloc_req_o), 64'(eq));
            if (eq) begin
                checkOutput("alloc_id_o", 64'(alloc_id_o), 64'(ax_id_i));
                checkOutput("alloc_len_o", 64'(alloc_len_o), 64'(ax_len_i));
            end
            if (ev) begin
                checkOutput("ax_addr_o", ax_addr_o, exp_q[0].addr);
                checkOutput("ax_last_o", 64'(ax_last_o), 64'(exp_q[0].last));
                checkOutput("ax_id_o", 64'(ax_id_o), 64'(cur_id));
                checkOutput("ax_size_o", 64'(ax_size_o), 64'(cur_size));
                checkOutput("ax_user_o", 64'(ax_user_o), 64'(cur_user));
                checkOutput("ax_misc_o", 64'(ax_misc_o), 64'(cur_misc));
                checkOutput("ax_len_o", 64'(ax_len_o), 64'd0);
                checkOutput("ax_burst_o", 64'(ax_burst_o), 64'(BURST_INCR));
            end
            if (ax_valid_o && ax_ready_i && !rst_i) begin
                log_addr.push_back(ax_addr_o);
                log_last.push_back(ax_last_o);
            end
        end
    end

    task automatic randomizeEnv();
        if (rand_mode) begin
            ax_ready_i  = 1'($urandom_range(0, 1));
            alloc_gnt_i = 1'($urandom_range(0, 1));
        end
    endtask

    // Present one burst and hold it until the model sees it accepted.
    task automatic applyStimulus(input logic [IW-1:0] id, input logic [63:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        int start;
        bit done;
        start      = acc_cnt;
        done       = 1'b0;
        ax_id_i    = id;
        ax_addr_i  = addr;
        ax_len_i   = len;
        ax_size_i  = size;
        ax_burst_i = burst;
        ax_user_i  = UW'($urandom);
        ax_misc_i  = MW'($urandom);
        ax_valid_i = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk_i);
            #2;
            if (acc_cnt != start) done = 1'b1;
            else randomizeEnv();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: got no accept, expected one within 3000 cycles");
        end
        ax_valid_i = 1'b0;
        randomizeEnv();
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            if (exp_q.size() == 0) done = 1'b1;
            else begin
                @(posedge clk_i);
                #2;
                randomizeEnv();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: got %0d beats pending, expected 0", exp_q.size());
        end
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_last.delete();
    endtask

    initial begin
        logic [1:0] b;
        logic [7:0] l;
        rst_i = 1'b1; ax_valid_i = 1'b0; ax_ready_i = 1'b0; alloc_gnt_i = 1'b0;
        ax_id_i = '0; ax_addr_i = '0; ax_len_i = '0; ax_size_i = '0; ax_burst_i = '0;
        ax_user_i = '0; ax_misc_i = '0;
        @(posedge clk_i);
        check_en = 1'b1;
        ax_valid_i = 1'b1; alloc_gnt_i = 1'b1; ax_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("reset ax_valid_o", 64'(ax_valid_o), 64'd0);
        checkOutput("reset ax_ready_o", 64'(ax_ready_o), 64'd0);
        checkOutput("reset alloc_req_o", 64'(alloc_req_o), 64'd0);
        @(posedge clk_i); #2;
        ax_valid_i = 1'b0;
        rst_i = 1'b0;

        clearLog();
        applyStimulus(4'd3, 64'h1002, 8'd3, 3'd2, BURST_INCR);
        waitIdle();
        want_addr = {64'h1002, 64'h1004, 64'h1008, 64'h100C};
        want_last = {1'b0, 1'b0, 1'b0, 1'b1};
        checkLog("incr");

        clearLog();
        applyStimulus(4'd5, 64'h1008, 8'd3, 3'd2, BURST_WRAP);
        waitIdle();
        want_addr = {64'h1008, 64'h100C, 64'h1000, 64'h1004};
        checkLog("wrap");

        clearLog();
        applyStimulus(4'd1, 64'h40, 8'd2, 3'd2, BURST_FIXED);
        @(posedge clk_i); #2;
        ax_ready_i = 1'b0;
        repeat (5) begin @(posedge clk_i); #2; end
        ax_ready_i = 1'b1;
        waitIdle();
        want_addr = {64'h40, 64'h40, 64'h40};
        want_last = {1'b0, 1'b0, 1'b1};
        checkLog("fixed stall");

        alloc_gnt_i = 1'b0;
        ax_id_i = 4'd7; ax_addr_i = 64'h2000; ax_len_i = 8'd1; ax_size_i = 3'd3;
        ax_burst_i = BURST_INCR; ax_valid_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            checkOutput("nogrant ax_ready_o", 64'(ax_ready_o), 64'd0);
            checkOutput("nogrant ax_valid_o", 64'(ax_valid_o), 64'd0);
            @(posedge clk_i); #2;
        end
        alloc_gnt_i = 1'b1;
        @(negedge clk_i);
        checkOutput("grant ax_ready_o", 64'(ax_ready_o), 64'd1);
        @(posedge clk_i); #2;
        ax_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("grant first beat valid", 64'(ax_valid_o), 64'd1);
        checkOutput("grant first beat addr", ax_addr_o, 64'h2000);
        waitIdle();

        clearLog();
        acc_time.delete();
        for (int k = 0; k < 4; k++) applyStimulus(4'(k), 64'h100 * 64'(k), 8'd0, 3'd1, BURST_INCR);
        waitIdle();
        for (int k = 0; k < 3; k++)
            checkOutput("b2b accept spacing", 64'(acc_time[k+1] - acc_time[k]), 64'd20);
        want_addr = {64'h0, 64'h100, 64'h200, 64'h300};
        want_last = {1'b1, 1'b1, 1'b1, 1'b1};
        checkLog("b2b len0");

        clearLog();
        applyStimulus(4'd2, 64'hFFFF_FFFF_FFFF_FFFC, 8'd1, 3'd2, BURST_INCR);
        waitIdle();
        want_addr = {64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        want_last = {1'b0, 1'b1};
        checkLog("overflow");

        applyStimulus(4'd4, 64'h3000, 8'd7, 3'd2, BURST_INCR);
        @(posedge clk_i); #2;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("mid reset ax_valid_o", 64'(ax_valid_o), 64'd0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post reset ax_valid_o", 64'(ax_valid_o), 64'd0);
        clearLog();
        applyStimulus(4'd9, 64'h3100, 8'd1, 3'd2, BURST_INCR);
        waitIdle();
        want_addr = {64'h3100, 64'h3104};
        want_last = {1'b0, 1'b1};
        checkLog("post reset");

        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            b = 2'($urandom_range(0, 3));
            l = 8'($urandom_range(0, 12));
            if (b == BURST_WRAP && $urandom_range(0, 3) != 0) l = 8'((1 << $urandom_range(1, 4)) - 1);
            if (n == 30) l = 8'd255;
            applyStimulus(IW'($urandom), {$urandom, $urandom}, l, 3'($urandom_range(0, 7)), b);
        end
        rand_mode = 1'b0;
        ax_ready_i = 1'b1;
        waitIdle();
        repeat (2) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
